bcd_to_7seg: RTL and testbench
==============================

BCD_TO_7SEG -- requirements
Module: bcd_to_7seg

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 0, SHALL invert all seg_out bits when 1 (common-anode drive); 0 = segment lit by logic 1.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  load strobe; a new code SHALL be captured only in cycles where en=1.
REQ-005 bcd_in  input  4  code to decode, 0-15.
REQ-006 hex_en  input  1  1 = codes 10-15 decode as hex glyphs; 0 = codes 10-15 are invalid.
REQ-007 blank  input  1  1 = force all segments off.
REQ-008 lamp_test  input  1  1 = force all segments on.
REQ-009 seg_out  output  7  registered segment drive; bit 6 = a, 5 = b, 4 = c, 3 = d, 2 = e, 1 = f, 0 = g.
REQ-010 invalid  output  1  registered flag; 1 = last captured code was not displayable.

Function
REQ-011 Logical segment pattern (a..g, 1 = lit) SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-012 With hex_en=1, codes 10-15 SHALL decode as: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; invalid=0.
REQ-013 With hex_en=0, codes 10-15 SHALL give a logical pattern of 0000000 (blank) and invalid=1.
REQ-014 Codes 0-9 SHALL always give invalid=0, regardless of hex_en.
REQ-015 Priority SHALL be lamp_test > blank > decode; lamp_test=1 gives logical 1111111, and blank=1 gives logical 0000000.
REQ-016 invalid SHALL reflect only the bcd_in/hex_en decode and SHALL be unaffected by the blank and lamp_test overrides.
REQ-017 Latency SHALL be exactly one cycle: inputs sampled on edge N with en=1 appear on seg_out/invalid after edge N.
REQ-018 With en=0, seg_out and invalid SHALL hold their previous values, and changes on bcd_in, hex_en, blank and lamp_test SHALL have no effect.
REQ-019 Physical seg_out SHALL equal the logical pattern XOR {7{SEG_ACTIVE_LOW}}, with the polarity applied after the priority mux.
REQ-020 No combinational path SHALL exist from any input to seg_out or invalid.
REQ-021 If bcd_in contains X/Z while en=1, no requirement applies to the outputs beyond the next valid load.

Reset
REQ-022 While rst_n=0, seg_out SHALL be the all-off pattern (0000000 when SEG_ACTIVE_LOW=0, 1111111 when 1) and invalid SHALL be 0, asynchronously, independent of clk.
REQ-023 Reset asserted mid-operation SHALL override any pending load in the same cycle.
REQ-024 After rst_n deasserts, the first en=1 rising edge SHALL load normally; outputs SHALL hold the reset values until then.

Verification
REQ-025 Sweep bcd_in 0-15 with en=1, hex_en=0, one code per cycle -> codes 0-9 match REQ-011 one cycle later with invalid=0; codes 10-15 give seg_out=0000000 with invalid=1.
REQ-026 Repeat the sweep with hex_en=1 -> code 10 gives 1110111 and code 15 gives 1000111, with invalid=0 for all codes.
REQ-027 Apply bcd_in=8, blank=1, lamp_test=1, en=1 -> seg_out=1111111; then lamp_test=0 -> 0000000; then blank=0 -> 1111111.
REQ-028 Load 5 (seg_out=1011011), then drive en=0 and bcd_in=2 for 3 cycles -> seg_out stays 1011011.
REQ-029 Pull rst_n low between clock edges while seg_out=1111001 -> seg_out becomes 0000000 immediately and invalid=0.
REQ-030 With SEG_ACTIVE_LOW=1, load 0 -> seg_out=0000001; under reset -> seg_out=1111111.

Source files
------------

// File: rtl/bcd_to_7seg_if.sv
// ----------------------------------------------------------------------------
// bcd_to_7seg_if
//   Bundles the load strobe, code, display controls and the registered
//   segment/flag outputs of the BCD to 7-segment decoder.
//
//   i_en         load strobe; a new code is captured only when 1
//   i_bcd_in     4-bit code to decode (0-15)
//   i_hex_en     1 = codes 10-15 decode as hex glyphs, 0 = flagged invalid
//   i_blank      1 = force all segments off
//   i_lamp_test  1 = force all segments on (wins over i_blank)
//   o_seg_out    registered segment drive, bit 6 = a ... bit 0 = g
//   o_invalid    registered flag, 1 = last captured code was not displayable
//
//   master : drives the controls, observes the outputs (testbench / host)
//   slave  : the decoder itself
// ----------------------------------------------------------------------------
interface bcd_to_7seg_if;
    logic       i_en;
    logic [3:0] i_bcd_in;
    logic       i_hex_en;
    logic       i_blank;
    logic       i_lamp_test;
    logic [6:0] o_seg_out;
    logic       o_invalid;

    modport master (
        output i_en,
        output i_bcd_in,
        output i_hex_en,
        output i_blank,
        output i_lamp_test,
        input  o_seg_out,
        input  o_invalid
    );

    modport slave (
        input  i_en,
        input  i_bcd_in,
        input  i_hex_en,
        input  i_blank,
        input  i_lamp_test,
        output o_seg_out,
        output o_invalid
    );
endinterface

// File: rtl/bcd_to_7seg.sv
// ----------------------------------------------------------------------------
// bcd_to_7seg
//   Registered BCD / hex to 7-segment decoder with blank and lamp-test
//   overrides and selectable output polarity. One cycle of latency from an
//   en=1 sample to the outputs; outputs hold while en=0.
//
//   Parameters
//     SEG_ACTIVE_LOW  0 = segment lit by logic 1, 1 = common-anode (inverted)
//
//   Ports
//     clk     single clock, rising edge
//     rst_n   asynchronous active-low reset; outputs go to all-off, flag 0
//     io_bus  bcd_to_7seg_if.slave (controls in, o_seg_out/o_invalid out)
// ----------------------------------------------------------------------------
module bcd_to_7seg #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_to_7seg_if.slave        io_bus
);

    // Logical glyphs, a..g with a in bit 6, 1 = lit.
    localparam logic [6:0] GLYPH_0   = 7'b1111110;
    localparam logic [6:0] GLYPH_1   = 7'b0110000;
    localparam logic [6:0] GLYPH_2   = 7'b1101101;
    localparam logic [6:0] GLYPH_3   = 7'b1111001;
    localparam logic [6:0] GLYPH_4   = 7'b0110011;
    localparam logic [6:0] GLYPH_5   = 7'b1011011;
    localparam logic [6:0] GLYPH_6   = 7'b1011111;
    localparam logic [6:0] GLYPH_7   = 7'b1110000;
    localparam logic [6:0] GLYPH_8   = 7'b1111111;
    localparam logic [6:0] GLYPH_9   = 7'b1111011;
    localparam logic [6:0] GLYPH_A   = 7'b1110111;
    localparam logic [6:0] GLYPH_B   = 7'b0011111;
    localparam logic [6:0] GLYPH_C   = 7'b1001110;
    localparam logic [6:0] GLYPH_D   = 7'b0111101;
    localparam logic [6:0] GLYPH_E   = 7'b1001111;
    localparam logic [6:0] GLYPH_F   = 7'b1000111;
    localparam logic [6:0] GLYPH_OFF = 7'b0000000;
    localparam logic [6:0] GLYPH_ON  = 7'b1111111;

    // XOR mask turning a logical pattern into the physical drive.
    localparam logic [6:0] SEG_POLARITY = {7{SEG_ACTIVE_LOW}};

    logic [6:0] w_glyph;        // raw decode of the code, hex glyphs included
    logic       w_is_hex;       // code is in the 10-15 range
    logic [6:0] w_decoded;      // glyph after hex_en qualification
    logic       w_invalid;      // decode-only flag, ignores blank/lamp_test
    logic [6:0] w_logical;      // after lamp_test > blank > decode priority
    logic [6:0] w_physical;     // polarity applied

    logic [6:0] r_seg;
    logic       r_invalid;

    // Raw glyph lookup. Unknown codes fall to blank so X on the input
    // cannot propagate as a half-lit pattern.
    always_comb begin
        w_glyph = GLYPH_OFF;
        case (io_bus.i_bcd_in)
            4'd0:    w_glyph = GLYPH_0;
            4'd1:    w_glyph = GLYPH_1;
            4'd2:    w_glyph = GLYPH_2;
            4'd3:    w_glyph = GLYPH_3;
            4'd4:    w_glyph = GLYPH_4;
            4'd5:    w_glyph = GLYPH_5;
            4'd6:    w_glyph = GLYPH_6;
            4'd7:    w_glyph = GLYPH_7;
            4'd8:    w_glyph = GLYPH_8;
            4'd9:    w_glyph = GLYPH_9;
            4'd10:   w_glyph = GLYPH_A;
            4'd11:   w_glyph = GLYPH_B;
            4'd12:   w_glyph = GLYPH_C;
            4'd13:   w_glyph = GLYPH_D;
            4'd14:   w_glyph = GLYPH_E;
            4'd15:   w_glyph = GLYPH_F;
            default: w_glyph = GLYPH_OFF;
        endcase
    end

    // Codes 10-15 are only displayable when hex mode is on; otherwise they
    // blank and raise the flag. Codes 0-9 never raise the flag.
    always_comb begin
        w_is_hex  = (io_bus.i_bcd_in > 4'd9);
        w_invalid = w_is_hex && !io_bus.i_hex_en;
        w_decoded = w_invalid ? GLYPH_OFF : w_glyph;
    end

    // Override priority, then polarity on the final logical pattern.
    always_comb begin
        w_logical = w_decoded;
        if (io_bus.i_lamp_test) begin
            w_logical = GLYPH_ON;
        end else if (io_bus.i_blank) begin
            w_logical = GLYPH_OFF;
        end
        w_physical = w_logical ^ SEG_POLARITY;
    end

    // Output registers: reset to the physical all-off pattern, load only on en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg     <= GLYPH_OFF ^ SEG_POLARITY;
            r_invalid <= 1'b0;
        end else if (io_bus.i_en) begin
            r_seg     <= w_physical;
            r_invalid <= w_invalid;
        end
    end

    assign io_bus.o_seg_out = r_seg;
    assign io_bus.o_invalid = r_invalid;

endmodule

// File: tb/tb_bcd_to_7seg.sv
// ----------------------------------------------------------------------------
// tb_bcd_to_7seg
//   Directed bench for bcd_to_7seg. Two instances share clock, reset and
//   stimulus: u_dut_hi (SEG_ACTIVE_LOW=0) and u_dut_lo (SEG_ACTIVE_LOW=1).
//   Expected values are hand-written glyph constants.
// ----------------------------------------------------------------------------
module tb_bcd_to_7seg;

    logic clk;
    logic rst_n;

    bcd_to_7seg_if bus_hi ();
    bcd_to_7seg_if bus_lo ();

    bcd_to_7seg #(.SEG_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_hi)
    );

    bcd_to_7seg #(.SEG_ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Hand-computed logical glyphs, a in bit 6.
    logic [6:0] glyph_tbl [16];
    initial begin
        glyph_tbl[0]  = 7'h7E; glyph_tbl[1]  = 7'h30; glyph_tbl[2]  = 7'h6D;
        glyph_tbl[3]  = 7'h79; glyph_tbl[4]  = 7'h33; glyph_tbl[5]  = 7'h5B;
        glyph_tbl[6]  = 7'h5F; glyph_tbl[7]  = 7'h70; glyph_tbl[8]  = 7'h7F;
        glyph_tbl[9]  = 7'h7B; glyph_tbl[10] = 7'h77; glyph_tbl[11] = 7'h1F;
        glyph_tbl[12] = 7'h4E; glyph_tbl[13] = 7'h3D; glyph_tbl[14] = 7'h4F;
        glyph_tbl[15] = 7'h47;
    end

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Both instances must show the same logical result; the inverted one
    // carries the complement on the segment bus.
    task automatic check_out(input string tag, input logic [6:0] exp_seg, input logic exp_inv);
        check({tag, " seg"},     {1'b0, bus_hi.o_seg_out}, {1'b0, exp_seg});
        check({tag, " inv"},     {7'b0, bus_hi.o_invalid}, {7'b0, exp_inv});
        check({tag, " seg_al"},  {1'b0, bus_lo.o_seg_out}, {1'b0, ~exp_seg});
        check({tag, " inv_al"},  {7'b0, bus_lo.o_invalid}, {7'b0, exp_inv});
    endtask

    task automatic drive(input logic en, input logic [3:0] bcd, input logic hex,
                         input logic blank, input logic lamp);
        bus_hi.i_en = en;  bus_hi.i_bcd_in = bcd;  bus_hi.i_hex_en = hex;
        bus_hi.i_blank = blank;  bus_hi.i_lamp_test = lamp;
        bus_lo.i_en = en;  bus_lo.i_bcd_in = bcd;  bus_lo.i_hex_en = hex;
        bus_lo.i_blank = blank;  bus_lo.i_lamp_test = lamp;
    endtask

    // Drive between edges, let one rising edge pass, land on the falling edge.
    task automatic step(input logic en, input logic [3:0] bcd, input logic hex,
                        input logic blank, input logic lamp);
        drive(en, bcd, hex, blank, lamp);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        // Asynchronous reset, before any clock edge.
        check_out("reset_async", 7'h00, 1'b0);

        // A load attempted under reset must not take effect.
        step(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        check_out("reset_over_load", 7'h00, 1'b0);

        // Release reset between edges; outputs hold reset values until en=1.
        drive(1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
        check_out("post_reset_hold", 7'h00, 1'b0);

        // Sweep with hex disabled.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
            if (i < 10) check_out($sformatf("dec_%0d", i), glyph_tbl[i], 1'b0);
            else        check_out($sformatf("dec_%0d", i), 7'h00, 1'b1);
        end

        // Sweep with hex enabled.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
            check_out($sformatf("hex_%0d", i), glyph_tbl[i], 1'b0);
        end

        // Override priority.
        step(1'b1, 4'd8, 1'b0, 1'b1, 1'b1);
        check_out("lamp_over_blank", 7'h7F, 1'b0);
        step(1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
        check_out("blank", 7'h00, 1'b0);
        step(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        check_out("unblank", 7'h7F, 1'b0);

        // Flag tracks the decode even when overridden.
        step(1'b1, 4'd12, 1'b0, 1'b0, 1'b1);
        check_out("lamp_invalid", 7'h7F, 1'b1);
        step(1'b1, 4'd13, 1'b0, 1'b1, 1'b0);
        check_out("blank_invalid", 7'h00, 1'b1);
        step(1'b1, 4'd4, 1'b0, 1'b1, 1'b0);
        check_out("blank_valid", 7'h00, 1'b0);

        // Hold while en=0, even with other inputs moving.
        step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        check_out("load_5", 7'h5B, 1'b0);
        step(1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
        check_out("hold_1", 7'h5B, 1'b0);
        step(1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
        check_out("hold_2", 7'h5B, 1'b0);
        step(1'b0, 4'd11, 1'b0, 1'b1, 1'b0);
        check_out("hold_3", 7'h5B, 1'b0);

        // Mid-operation reset between edges.
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        check_out("load_3", 7'h79, 1'b0);
        drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_out("mid_reset", 7'h00, 1'b0);
        check("mid_reset_al_raw", {1'b0, bus_lo.o_seg_out}, 8'h7F);
        @(posedge clk);
        @(negedge clk);
        check_out("mid_reset_edge", 7'h00, 1'b0);

        // Release and first load; active-low instance shows 0000001 for '0'.
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_out("release_hold", 7'h00, 1'b0);
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        check_out("load_0", 7'h7E, 1'b0);
        check("load_0_al_raw", {1'b0, bus_lo.o_seg_out}, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
